// File: rtl/sink_bit_packer.sv
// rtl/sink_bit_packer.sv - serial bit packer feeding a word FIFO with valid/ready output
//
// Packs qualified serial bits (LSB first) into WORD_W-bit words and buffers them
// in a DEPTH-entry FIFO. A partial word may be pushed with flush. Words pushed
// while the FIFO is full and not popping are dropped and counted.
//
// Optional feature macro: SINK_PARITY_EN (adds out_parity, even parity per entry).
//
// Ports:
//   clk        clock, all state on posedge
//   rst_n      asynchronous active-low reset
//   in_valid   in_bit qualified this cycle
//   in_bit     serial data bit
//   flush      push current partial word
//   out_valid  FIFO non-empty
//   out_ready  consumer accepts head word
//   out_data   head word, bit i = i-th received bit (0 when empty)
//   out_count  number of valid bits in out_data (0 when empty)
//   full       FIFO holds DEPTH words
//   drop_cnt   saturating count of dropped words
//   out_parity even parity of head word (SINK_PARITY_EN only)
module sink_bit_packer #(
  parameter int WORD_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  input  logic                          in_bit,
  input  logic                          flush,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [WORD_W-1:0]             out_data,
  output logic [$clog2(WORD_W+1)-1:0]   out_count,
  output logic                          full,
  output logic [7:0]                    drop_cnt
`ifdef SINK_PARITY_EN
  ,
  output logic                          out_parity
`endif
);

  localparam int CW = $clog2(WORD_W + 1);
  localparam int IW = $clog2(WORD_W);
  localparam int AW = $clog2(DEPTH);

  logic [WORD_W-1:0] word, word_nxt;
  logic [CW-1:0]     bit_idx, idx_nxt;
  logic              push, pop, accept, drop, empty;

  logic [WORD_W-1:0] mem_data [DEPTH];
  logic [CW-1:0]     mem_cnt  [DEPTH];
`ifdef SINK_PARITY_EN
  logic              mem_par  [DEPTH];
`endif
  logic [AW:0]       wr_ptr, rd_ptr, occ;

  // Word as it stands after this cycle's bit; pushed directly when complete or flushed.
  always_comb begin
    word_nxt = word;
    idx_nxt  = bit_idx;
    if (in_valid) begin
      word_nxt[bit_idx[IW-1:0]] = in_bit;
      idx_nxt                   = bit_idx + CW'(1);
    end
    push = (idx_nxt == CW'(WORD_W)) || (flush && (idx_nxt != '0));
  end

  // Pointers carry an extra wrap bit so full and empty are distinguishable.
  assign occ    = wr_ptr - rd_ptr;
  assign empty  = (occ == '0);
  assign full   = (occ == (AW+1)'(DEPTH));
  assign pop    = !empty && out_ready;
  // A same-cycle pop frees a slot, so a push into a full FIFO is still accepted.
  assign accept = push && (!full || pop);
  assign drop   = push && full && !pop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word     <= '0;
      bit_idx  <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      drop_cnt <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_data[i] <= '0;
        mem_cnt[i]  <= '0;
`ifdef SINK_PARITY_EN
        mem_par[i]  <= 1'b0;
`endif
      end
    end else begin
      if (push) begin
        word    <= '0;
        bit_idx <= '0;
      end else begin
        word    <= word_nxt;
        bit_idx <= idx_nxt;
      end
      if (accept) begin
        mem_data[wr_ptr[AW-1:0]] <= word_nxt;
        mem_cnt[wr_ptr[AW-1:0]]  <= idx_nxt;
`ifdef SINK_PARITY_EN
        // Bits above the valid count are zero, so XOR of the whole word suffices.
        mem_par[wr_ptr[AW-1:0]]  <= ^word_nxt;
`endif
        wr_ptr <= wr_ptr + (AW+1)'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + (AW+1)'(1);
      end
      if (drop && (drop_cnt != 8'hFF)) begin
        drop_cnt <= drop_cnt + 8'd1;
      end
    end
  end

  assign out_valid  = !empty;
  assign out_data   = empty ? '0 : mem_data[rd_ptr[AW-1:0]];
  assign out_count  = empty ? '0 : mem_cnt[rd_ptr[AW-1:0]];
`ifdef SINK_PARITY_EN
  assign out_parity = empty ? 1'b0 : mem_par[rd_ptr[AW-1:0]];
`endif

endmodule

// File: tb/tb_sink_bit_packer.sv
// tb/tb_sink_bit_packer.sv - self-checking bench for sink_bit_packer
module tb_sink_bit_packer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_bit = 1'b0;
  logic       flush = 1'b0;
  logic       out_ready = 1'b0;
  logic       out_valid;
  logic [7:0] out_data;
  logic [3:0] out_count;
  logic       full;
  logic [7:0] drop_cnt;
`ifdef SINK_PARITY_EN
  logic       out_parity;
`endif

  int checks = 0;
  int failures = 0;

  sink_bit_packer #(.WORD_W(8), .DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_bit(in_bit), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_count(out_count), .full(full), .drop_cnt(drop_cnt)
`ifdef SINK_PARITY_EN
    , .out_parity(out_parity)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: list of received bits and a queue of finished words.
  logic [7:0] m_acc = '0;
  int         m_nbits = 0;
  logic [7:0] q_data [$];
  int         q_cnt  [$];
  int         m_drop = 0;

  always @(negedge rst_n) begin
    m_acc = '0; m_nbits = 0; q_data.delete(); q_cnt.delete(); m_drop = 0;
  end

  always @(posedge clk) begin
    if (rst_n) begin
      automatic bit popping = (q_data.size() > 0) && out_ready;
      automatic bit emit;
      if (in_valid) begin
        m_acc = m_acc | (8'(in_bit) << m_nbits);
        m_nbits++;
      end
      emit = (m_nbits == 8) || (flush && m_nbits > 0);
      if (popping) begin
        void'(q_data.pop_front());
        void'(q_cnt.pop_front());
      end
      if (emit) begin
        if (q_data.size() < 4) begin
          q_data.push_back(m_acc);
          q_cnt.push_back(m_nbits);
        end else if (m_drop < 255) begin
          m_drop++;
        end
        m_acc = '0;
        m_nbits = 0;
      end
    end
  end

  always @(negedge clk) begin
    automatic bit ne = q_data.size() > 0;
    chk("out_valid", out_valid, ne);
    chk("full", full, q_data.size() == 4);
    chk("drop_cnt", drop_cnt, m_drop);
    chk("out_data", out_data, ne ? q_data[0] : 8'h00);
    chk("out_count", out_count, ne ? q_cnt[0] : 0);
`ifdef SINK_PARITY_EN
    chk("out_parity", out_parity, ne ? ($countones(q_data[0]) % 2) : 0);
`endif
  end

  task automatic cyc(input logic iv, input logic ib, input logic fl, input logic rdy);
    in_valid = iv; in_bit = ib; flush = fl; out_ready = rdy;
    @(posedge clk); #2;
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
  endtask

  task automatic send(input logic [7:0] d, input int n, input logic fl);
    for (int i = 0; i < n; i++) cyc(1'b1, d[i], (i == n-1) ? fl : 1'b0, 1'b0);
  endtask

  task automatic pop_expect(input string name, input logic [7:0] d);
    chk(name, out_data, d);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    logic [7:0] w5 [5];
    w5 = '{8'hA5, 8'h3C, 8'hFF, 8'h01, 8'h80};
    repeat (2) @(posedge clk);
    #2;
    chk("reset out_valid", out_valid, 0);
    chk("reset out_data", out_data, 0);
    chk("reset drop_cnt", drop_cnt, 0);
    rst_n = 1'b1;

    // 1,0,1,1,0,0,1,0 -> 8'h4D
    send(8'h4D, 8, 1'b0);
    chk("first word valid", out_valid, 1);
    chk("first word data", out_data, 8'h4D);
    chk("first word count", out_count, 8);
    chk("first word full", full, 0);
`ifdef SINK_PARITY_EN
    chk("parity 4D", out_parity, 0);
`endif
    cyc(1'b0, 1'b0, 1'b0, 1'b1);

    // partial 1,1,0 + flush, then an empty flush
    send(8'h03, 3, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    chk("partial data", out_data, 8'h03);
    chk("partial count", out_count, 3);
`ifdef SINK_PARITY_EN
    chk("parity 011", out_parity, 0);
`endif
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    pop_expect("partial pop", 8'h03);
    chk("no empty word", out_valid, 0);

`ifdef SINK_PARITY_EN
    send(8'h01, 3, 1'b1);
    chk("parity 001", out_parity, 1);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
`endif

    // overflow: 5 words into a 4-deep FIFO
    for (int k = 0; k < 5; k++) begin
      send(w5[k], 8, 1'b0);
      if (k == 3) chk("full after 4", full, 1);
    end
    chk("drop after 5", drop_cnt, 1);
    chk("head kept", out_data, 8'hA5);
    for (int k = 0; k < 4; k++) pop_expect("overflow order", w5[k]);
    chk("drained", out_valid, 0);

    // full + pop + completing bit in the same cycle
    send(8'h10, 8, 1'b0); send(8'h20, 8, 1'b0);
    send(8'h30, 8, 1'b0); send(8'h40, 8, 1'b0);
    send(8'h5E, 7, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b1);
    chk("push+pop full", full, 1);
    chk("push+pop no drop", drop_cnt, 1);
    pop_expect("pp 1", 8'h20);
    pop_expect("pp 2", 8'h30);
    pop_expect("pp 3", 8'h40);
    pop_expect("pp last", 8'h5E);
    chk("pp drained", out_valid, 0);

    // asynchronous reset with two words queued and five bits pending
    send(8'h77, 8, 1'b0); send(8'h99, 8, 1'b0);
    send(8'h1F, 5, 1'b0);
    #1 rst_n = 1'b0;
    #1;
    chk("async rst valid", out_valid, 0);
    chk("async rst drop", drop_cnt, 0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    send(8'h05, 3, 1'b1);
    chk("post rst count", out_count, 3);
    pop_expect("post rst data", 8'h05);
    chk("post rst only one", out_valid, 0);

    repeat (2) @(posedge clk);
    #2;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
